// File: rtl/apb_led_pwm_if.sv
// APB3 slave bus bundle for the LED PWM controller.
interface apb_led_pwm_if;
    logic        PSEL;
    logic [15:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_led_pwm.sv
// APB-controlled LED driver: per-channel PWM duty, global prescaler and blink gating.
// LED output is two register stages behind the control/data registers.
module apb_led_pwm #(
    parameter int unsigned NUM_LED   = 8,
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_led_pwm_if.slave       apb,
    input  logic [3:0]         ECOREVNUM,
    output logic [NUM_LED-1:0] LED
);
    localparam logic [31:0] LP_NUM_LED   = 32'(NUM_LED);
    localparam logic [31:0] LP_PWM_W     = 32'(PWM_WIDTH);
    localparam logic [9:0]  LP_DUTY_BASE = 10'h010;

    logic [NUM_LED-1:0]   r_data;
    logic [1:0]           r_ctrl;
    logic [15:0]          r_prescale;
    logic [15:0]          r_blink;
    logic [PWM_WIDTH-1:0] r_duty [NUM_LED];
    logic [15:0]          r_pre_cnt;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic [15:0]          r_blink_cnt;
    logic                 r_blink_phase;
    logic [NUM_LED-1:0]   r_led_d;
    logic [NUM_LED-1:0]   r_led;

    logic [9:0]           w_idx;
    logic                 w_wr;
    logic                 w_duty_hit;
    logic [31:0]          w_duty_rd;
    logic                 w_mapped;
    logic [31:0]          w_rdata;
    logic                 w_clr;
    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_phase;
    logic [NUM_LED-1:0]   w_pwm_on;
    logic [NUM_LED-1:0]   w_led_next;
    logic                 w_unused_bits;

    assign w_idx         = apb.PADDR[11:2];
    assign w_wr          = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_unused_bits = ^{apb.PADDR[15:12], apb.PADDR[1:0], apb.PWDATA[31:16]};

    always_comb begin
        w_duty_hit = 1'b0;
        w_duty_rd  = '0;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            if (w_idx == LP_DUTY_BASE + 10'(i)) begin
                w_duty_hit = 1'b1;
                w_duty_rd  = 32'(r_duty[i]);
            end
        end
    end

    assign w_mapped = (w_idx <= 10'd4) | w_duty_hit;

    always_comb begin
        w_rdata = w_duty_rd;
        case (w_idx)
            10'd0:   w_rdata = 32'(r_data);
            10'd1:   w_rdata = {30'h0, r_ctrl};
            10'd2:   w_rdata = {16'h0, r_prescale};
            10'd3:   w_rdata = {16'h0, r_blink};
            10'd4:   w_rdata = {16'h0, LP_NUM_LED[7:0], LP_PWM_W[3:0], ECOREVNUM};
            default: w_rdata = w_duty_rd;
        endcase
    end

    assign apb.PRDATA  = (apb.PSEL & ~apb.PWRITE) ? w_rdata : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~w_mapped;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_data     <= '0;
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_blink    <= '0;
            for (int unsigned i = 0; i < NUM_LED; i++) r_duty[i] <= '0;
        end else if (w_wr) begin
            case (w_idx)
                10'd0:   r_data     <= apb.PWDATA[NUM_LED-1:0];
                10'd1:   r_ctrl     <= apb.PWDATA[1:0];
                10'd2:   r_prescale <= apb.PWDATA[15:0];
                10'd3:   r_blink    <= apb.PWDATA[15:0];
                default: ;
            endcase
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                if (w_idx == LP_DUTY_BASE + 10'(i)) r_duty[i] <= apb.PWDATA[PWM_WIDTH-1:0];
            end
        end
    end

    // CTRL/PRESCALE writes restart the whole timebase and win over a coincident tick/wrap.
    assign w_clr   = w_wr & ((w_idx == 10'd1) | (w_idx == 10'd2));
    assign w_tick  = (r_pre_cnt == r_prescale);
    assign w_wrap  = w_tick & (r_pwm_cnt == '1);
    assign w_phase = (r_blink == '0) | r_blink_phase;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pre_cnt     <= '0;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_clr) begin
            r_pre_cnt     <= '0;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 16'd1;
            if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
            if (r_blink == '0) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (w_wrap) begin
                if (r_blink_cnt == r_blink - 16'd1) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_pwm_on = '0;
        for (int unsigned i = 0; i < NUM_LED; i++) w_pwm_on[i] = (r_pwm_cnt < r_duty[i]);
    end

    assign w_led_next = r_data
                      & (r_ctrl[0] ? w_pwm_on : '1)
                      & (r_ctrl[1] ? {NUM_LED{w_phase}} : '1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_led_d <= '0;
            r_led   <= '0;
        end else begin
            r_led_d <= w_led_next;
            r_led   <= r_led_d;
        end
    end

    assign LED = r_led;
endmodule

// File: tb/tb_apb_led_pwm.sv
// Directed bench for apb_led_pwm (NUM_LED=8, PWM_WIDTH=8) with hand-computed expectations.
module tb_apb_led_pwm;
    logic       PCLK      = 1'b0;
    logic       PRESETn   = 1'b0;
    logic [3:0] ECOREVNUM = 4'hA;
    logic [7:0] LED;

    apb_led_pwm_if bus ();

    apb_led_pwm #(.NUM_LED(8), .PWM_WIDTH(8)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (bus),
        .ECOREVNUM (ECOREVNUM),
        .LED       (LED)
    );

    always #5 PCLK = ~PCLK;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, output logic err);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1 err = bus.PSLVERR;
        @(posedge PCLK);
        #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [15:0] a, output logic [31:0] d, output logic err);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1 begin d = bus.PRDATA; err = bus.PSLVERR; end
        @(posedge PCLK);
        #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wr_ok(input string tag, input logic [15:0] a, input logic [31:0] d);
        logic e;
        apb_wr(a, d, e);
        check(tag, 32'(e), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
        check(tag, d, exp);
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        int unsigned cnt0, cnt1, cnt2, cnt7;
        logic        s [1:1100];

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1 check("rst_led", 32'(LED), 32'h0);
        @(negedge PCLK) PRESETn = 1'b1;

        // reset values
        check("pready", 32'(bus.PREADY), 32'd1);
        rd_chk("rst_data",     16'h0000, 32'h0);
        rd_chk("rst_ctrl",     16'h0004, 32'h0);
        rd_chk("rst_prescale", 16'h0008, 32'h0);
        rd_chk("rst_blink",    16'h000C, 32'h0);
        rd_chk("rst_id",       16'h0010, 32'h0000_088A);
        rd_chk("rst_duty0",    16'h0040, 32'h0);
        rd_chk("rst_duty7",    16'h005C, 32'h0);

        // DATA with CTRL=0: two-edge latency
        wr_ok("data_wr_err", 16'h0000, 32'hFFFF_FFA5);
        @(posedge PCLK); #1 check("data_lat1", 32'(LED), 32'h00);
        @(posedge PCLK); #1 check("data_lat2", 32'(LED), 32'hA5);
        rd_chk("data_rd", 16'h0000, 32'h0000_00A5);

        // unmapped offsets, ID write, address aliasing, width truncation
        apb_wr(16'h0060, 32'hFFFF_FFFF, e); check("unmap60_wr_err", 32'(e), 32'd1);
        apb_rd(16'h0060, d, e);             check("unmap60_rd", d, 32'h0); check("unmap60_rd_err", 32'(e), 32'd1);
        apb_wr(16'h0020, 32'h0000_00FF, e); check("unmap20_wr_err", 32'(e), 32'd1);
        apb_rd(16'h0020, d, e);             check("unmap20_rd", d, 32'h0); check("unmap20_rd_err", 32'(e), 32'd1);
        rd_chk("unmap_no_effect_data", 16'h0000, 32'h0000_00A5);
        rd_chk("unmap_no_effect_duty7", 16'h005C, 32'h0);
        wr_ok("id_wr_err", 16'h0010, 32'hFFFF_FFFF);
        rd_chk("id_after_wr", 16'h0010, 32'h0000_088A);
        rd_chk("alias_data", 16'hF003, 32'h0000_00A5);
        wr_ok("prescale_wr", 16'h0008, 32'h1234_5678);
        rd_chk("prescale_trunc", 16'h0008, 32'h0000_5678);

        // PWM duty ratios with PRESCALE=0
        wr_ok("pwm_data", 16'h0000, 32'hFF);
        wr_ok("pwm_duty0", 16'h0040, 32'd64);
        wr_ok("pwm_duty1", 16'h0044, 32'd0);
        wr_ok("pwm_duty2", 16'h0048, 32'hFFFF_FFFF);
        rd_chk("duty2_trunc", 16'h0048, 32'h0000_00FF);
        wr_ok("pwm_prescale", 16'h0008, 32'd0);
        wr_ok("pwm_ctrl", 16'h0004, 32'd1);
        repeat (4) @(posedge PCLK);
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt7 = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge PCLK); #1;
            cnt0 += 32'(LED[0]); cnt1 += 32'(LED[1]); cnt2 += 32'(LED[2]); cnt7 += 32'(LED[7]);
        end
        check("pwm_cnt_led0", cnt0, 32'd64);
        check("pwm_cnt_led1", cnt1, 32'd0);
        check("pwm_cnt_led2", cnt2, 32'd255);
        check("pwm_cnt_led7", cnt7, 32'd0);

        // PRESCALE=3, DUTY0=2: LED0 high for edges W+2..W+9 after CTRL write at W
        wr_ok("ps3_duty0", 16'h0040, 32'd2);
        wr_ok("ps3_prescale", 16'h0008, 32'd3);
        wr_ok("ps3_ctrl", 16'h0004, 32'd1);
        for (int m = 1; m <= 10; m++) begin
            @(posedge PCLK); #1 s[m] = LED[0];
        end
        check("ps3_m2",  32'(s[2]),  32'd1);
        check("ps3_m9",  32'(s[9]),  32'd1);
        check("ps3_m10", 32'(s[10]), 32'd0);

        // blink BLINK=2: phase flips every 512 cycles
        wr_ok("blk_data", 16'h0000, 32'h01);
        wr_ok("blk_blink", 16'h000C, 32'd2);
        wr_ok("blk_prescale", 16'h0008, 32'd0);
        wr_ok("blk_ctrl", 16'h0004, 32'd2);
        for (int m = 1; m <= 1026; m++) begin
            @(posedge PCLK); #1 s[m] = LED[0];
        end
        check("blk_m513",  32'(s[513]),  32'd1);
        check("blk_m514",  32'(s[514]),  32'd0);
        check("blk_m1025", 32'(s[1025]), 32'd0);
        check("blk_m1026", 32'(s[1026]), 32'd1);

        // BLINK=0 forces phase high
        wr_ok("blk0_blink", 16'h000C, 32'd0);
        repeat (4) @(posedge PCLK);
        cnt0 = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge PCLK); #1 cnt0 += 32'(LED[0]);
        end
        check("blk0_held_high", cnt0, 32'd600);

        // CTRL write colliding with pwm_wrap: clear must win (no toggle)
        wr_ok("coll_blink", 16'h000C, 32'd1);
        wr_ok("coll_ctrl_a", 16'h0004, 32'd2);
        repeat (254) @(posedge PCLK);
        wr_ok("coll_ctrl_b", 16'h0004, 32'd2);
        for (int m = 1; m <= 258; m++) begin
            @(posedge PCLK); #1 s[m] = LED[0];
        end
        check("coll_m10",  32'(s[10]),  32'd1);
        check("coll_m257", 32'(s[257]), 32'd1);
        check("coll_m258", 32'(s[258]), 32'd0);

        // asynchronous reset mid-period
        wr_ok("rst2_data", 16'h0000, 32'hA5);
        wr_ok("rst2_ctrl", 16'h0004, 32'd0);
        wr_ok("rst2_prescale", 16'h0008, 32'd3);
        repeat (37) @(posedge PCLK);
        #1 check("rst2_led_before", 32'(LED), 32'hA5);
        #2 PRESETn = 1'b0;
        #1 check("rst2_led_async", 32'(LED), 32'h00);
        rd_chk("rst2_data_rd", 16'h0000, 32'h0);
        rd_chk("rst2_prescale_rd", 16'h0008, 32'h0);
        rd_chk("rst2_duty0_rd", 16'h0040, 32'h0);
        @(negedge PCLK) PRESETn = 1'b1;
        repeat (5) @(posedge PCLK);
        #1 check("rst2_led_after", 32'(LED), 32'h00);
        rd_chk("rst2_ctrl_rd", 16'h0004, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
